// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU opcodes,
// default datapath width and the EX-stage control bundle.
package id_ex_stage_pkg;

    localparam int BIT_SIZE = 32;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_NOR = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;
    localparam logic [3:0] ALU_BEQ = 4'd10;
    localparam logic [3:0] ALU_BNE = 4'd11;

    // Control/index half of the EX register; all-zero is the bubble.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [4:0] shamt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding select for one source register. EX/MEM beats MEM/WB;
// register $0 never forwards. With ID_EX_FORWARD_EN undefined the
// registered operand passes straight through.
module forward_unit #(
    parameter int bit_size = 32
) (
    input  logic [4:0]          src_idx,
    input  logic [bit_size-1:0] reg_data,
    input  logic                exmem_RegWrite,
    input  logic [4:0]          exmem_rd,
    input  logic [bit_size-1:0] exmem_result,
    input  logic                memwb_RegWrite,
    input  logic [4:0]          memwb_rd,
    input  logic [bit_size-1:0] memwb_result,
    output logic [bit_size-1:0] fwd_data
);

`ifdef ID_EX_FORWARD_EN
    // Priority select: youngest producer first.
    always_comb begin
        fwd_data = reg_data;
        if (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == src_idx))
            fwd_data = exmem_result;
        else if (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == src_idx))
            fwd_data = memwb_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{src_idx, exmem_RegWrite, exmem_rd, exmem_result,
                          memwb_RegWrite, memwb_rd, memwb_result};
    assign fwd_data   = reg_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Optional feature macro: ID_EX_FORWARD_EN (enables EX/MEM and MEM/WB
// forwarding; otherwise operands come straight from the register file read).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int bit_size = BIT_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [3:0]          id_ALUOp,
    input  logic [bit_size-1:0] id_rs_data,
    input  logic [bit_size-1:0] id_rt_data,
    input  logic [bit_size-1:0] id_imm,
    input  logic                id_ALUSrc,
    input  logic [4:0]          id_shamt,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic [4:0]          id_rd,
    input  logic                id_RegWrite,
    input  logic                id_MemRead,
    input  logic                exmem_RegWrite,
    input  logic [4:0]          exmem_rd,
    input  logic [bit_size-1:0] exmem_result,
    input  logic                memwb_RegWrite,
    input  logic [4:0]          memwb_rd,
    input  logic [bit_size-1:0] memwb_result,
    output logic [3:0]          ALUOp,
    output logic [bit_size-1:0] scr1,
    output logic [bit_size-1:0] scr2,
    output logic [4:0]          shamt,
    output logic                ex_valid,
    output logic                ex_RegWrite,
    output logic                ex_MemRead,
    output logic [4:0]          ex_rd,
    output logic [bit_size-1:0] ex_rt_fwd,
    output logic                load_use_stall
);

    ex_ctrl_t            ctrl_q;
    logic [bit_size-1:0] rs_data_q, rt_data_q, imm_q;

    // EX register: reset/flush insert a bubble, stall holds, else capture.
    // An invalid ID slot is captured with its side effects suppressed.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (!stall) begin
            ctrl_q.valid     <= id_valid;
            ctrl_q.reg_write <= id_RegWrite & id_valid;
            ctrl_q.mem_read  <= id_MemRead & id_valid;
            ctrl_q.alu_src   <= id_ALUSrc;
            ctrl_q.alu_op    <= id_ALUOp;
            ctrl_q.shamt     <= id_shamt;
            ctrl_q.rs        <= id_rs;
            ctrl_q.rt        <= id_rt;
            ctrl_q.rd        <= id_rd;
            rs_data_q        <= id_rs_data;
            rt_data_q        <= id_rt_data;
            imm_q            <= id_imm;
        end
    end

    // Index 0 = rs, index 1 = rt.
    logic [1:0][4:0]          src_idx;
    logic [1:0][bit_size-1:0] reg_data;
    logic [1:0][bit_size-1:0] fwd_data;

    assign src_idx  = {ctrl_q.rt, ctrl_q.rs};
    assign reg_data = {rt_data_q, rs_data_q};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        forward_unit #(.bit_size(bit_size)) u_fwd (
            .src_idx        (src_idx[g]),
            .reg_data       (reg_data[g]),
            .exmem_RegWrite (exmem_RegWrite),
            .exmem_rd       (exmem_rd),
            .exmem_result   (exmem_result),
            .memwb_RegWrite (memwb_RegWrite),
            .memwb_rd       (memwb_rd),
            .memwb_result   (memwb_result),
            .fwd_data       (fwd_data[g])
        );
    end

    assign scr1      = fwd_data[0];
    assign ex_rt_fwd = fwd_data[1];
    assign scr2      = ctrl_q.alu_src ? imm_q : fwd_data[1];

    assign ALUOp       = ctrl_q.alu_op;
    assign shamt       = ctrl_q.shamt;
    assign ex_rd       = ctrl_q.rd;
    assign ex_valid    = ctrl_q.valid;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemRead  = ctrl_q.mem_read;

    // A load in EX whose destination is read by the instruction in ID
    // cannot be forwarded in time; ask the front end to wait one cycle.
    assign load_use_stall = ctrl_q.valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) &
                            ((ctrl_q.rd == id_rs) | (ctrl_q.rd == id_rt));

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: bit_size, 32, datapath width of operands and results.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hold all pipeline registers this cycle.
REQ-005 flush  input  1  replace captured instruction with a bubble.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_ALUOp  input  4  ALU operation code from decoder.
REQ-008 id_rs_data, id_rt_data  input  bit_size  register-file read data.
REQ-009 id_imm  input  bit_size  sign/zero-extended immediate.
REQ-010 id_ALUSrc  input  1  1 = scr2 takes immediate.
REQ-011 id_shamt  input  5  shift amount.
REQ-012 id_rs, id_rt, id_rd  input  5 each  register indices; id_rd is the resolved destination.
REQ-013 id_RegWrite, id_MemRead  input  1 each  destination written / instruction is a load.
REQ-014 exmem_RegWrite, exmem_rd[4:0], exmem_result[bit_size]  input  EX/MEM forwarding source.
REQ-015 memwb_RegWrite, memwb_rd[4:0], memwb_result[bit_size]  input  MEM/WB forwarding source.
REQ-016 ALUOp[4], scr1[bit_size], scr2[bit_size], shamt[5]  output  operands to the ALU.
REQ-017 ex_valid, ex_RegWrite, ex_MemRead [1 each], ex_rd[5], ex_rt_fwd[bit_size]  output  EX-stage control and store data.
REQ-018 load_use_stall  output  1  request to stall IF/ID and flush this stage.

Function
REQ-019 On rising edge with rst=0, flush=0, stall=0: all id_* inputs SHALL be captured into EX registers (latency 1 cycle).
REQ-020 stall=1, flush=0: EX registers SHALL hold their values.
REQ-021 flush=1 (regardless of stall): EX registers SHALL load a bubble: valid=0, ALUOp=0 (nop), RegWrite=0, MemRead=0, rd=0, data fields 0.
REQ-022 id_valid=0 captured SHALL be treated as bubble (RegWrite, MemRead forced 0).
REQ-023 Forwarded rs value SHALL be: exmem_result if exmem_RegWrite and exmem_rd!=0 and exmem_rd==ex_rs; else memwb_result if memwb_RegWrite and memwb_rd!=0 and memwb_rd==ex_rs; else registered rs_data. Same rule for rt.
REQ-024 EX/MEM match SHALL take priority over MEM/WB when both match.
REQ-025 scr1 SHALL equal forwarded rs; scr2 SHALL equal registered imm when ALUSrc=1, else forwarded rt; ex_rt_fwd SHALL always equal forwarded rt.
REQ-026 Forward muxing and scr1/scr2 SHALL be combinational from EX registers and forwarding inputs (no extra cycle).
REQ-027 load_use_stall SHALL be combinational: ex_valid & ex_MemRead & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
REQ-028 ALUOp, shamt, ex_rd, ex_valid, ex_RegWrite, ex_MemRead SHALL come directly from EX registers.

Reset
REQ-029 rst=1 at a rising edge SHALL override stall and flush and load the bubble of REQ-021; all outputs then 0 except load_use_stall=0.

Configuration
REQ-030 Macro ID_EX_FORWARD_EN: defined -> REQ-023/024 forwarding active; undefined -> forwarded values SHALL equal registered rs_data/rt_data and forwarding inputs SHALL be unused.

Structure
REQ-031 ALUOp encodings (nop 0, add 1, sub 2, and 3, or 4, xor 5, nor 6, slt 7, sll 8, srl 9, beq 10, bne 11) and bit_size default SHALL live in the shared package.
REQ-032 Forwarding selection SHALL be a sub-module forward_unit, instantiated twice (rs, rt).

Verification
REQ-033 Capture: id_ALUOp=1, rs_data=5, rt_data=7, ALUSrc=0, one edge -> ALUOp=1, scr1=5, scr2=7, ex_valid=1.
REQ-034 Double forward: ex_rs=8, exmem_rd=8 result 0x11, memwb_rd=8 result 0x22, both RegWrite=1 -> scr1=0x11; exmem_RegWrite=0 -> scr1=0x22; rd=0 in both -> scr1=rs_data.
REQ-035 Load-use: EX holds MemRead=1, rd=9, id_rt=9 -> load_use_stall=1; id_rt=10 -> 0.
REQ-036 Stall then flush: stall=1 for 2 cycles with changing inputs -> outputs unchanged; stall=1 & flush=1 -> ALUOp=0, ex_valid=0.
REQ-037 Reset mid-stream: rst=1 with stall=1 and valid instruction in EX -> next edge all outputs 0.
REQ-038 Build without ID_EX_FORWARD_EN: REQ-034 stimulus -> scr1=rs_data.
